fetch_unit: RTL

Instruction-fetch front end: the consumer of the jump unit's redirect interface (newPC, ctrlFetch, halt). Holds the PC and issues word requests to instruction memory over a req/ready handshake. Buffers returned words in a small FIFO and hands {pc, instr} to decode. On a redirect it flushes the buffered stream and restarts at the target. On halt it freezes issue to decode.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, the NOP
// encoding, the fetch FSM states and the {pc, instr} FIFO entry layout.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_SPACE
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO of {pc, instr} entries. A flush empties it
// and overrides any push/pop in the same cycle; a pop frees a slot for a push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Flush drops the write pointer back to the read pointer so the head stays put.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues word requests from the PC, buffers
// returned words and presents {pc, instr} to decode; honours redirect and halt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrlFetch,
  input  logic [31:0] newPC,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        misaligned
);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   pc;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          has_space;
  fetch_entry_t  head;
  fetch_entry_t  din;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready && !ctrlFetch;
  assign dec_valid = !empty && !halt;
  assign pop       = dec_valid && dec_ready;
  assign push      = accept && (!full || pop);
  assign din       = '{pc: pc, instr: imem_data};
  assign dec_instr = dec_valid ? head.instr : NOP_INSTR;
  assign dec_pc    = head.pc;

  // Occupancy after this cycle's push/pop decides whether another request fits.
  assign count_next = count + CW'(push) - CW'(pop);
  assign has_space  = (count_next < CW'(DEPTH));

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .flush (ctrlFetch),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      state      <= state_next;
      misaligned <= ctrlFetch && (newPC[1:0] != 2'b00);
      if (ctrlFetch) begin
        pc <= {newPC[31:2], 2'b00};
      end else if (accept) begin
        pc <= pc + 32'd4;
      end
    end
  end

  // A started request is held until memory answers; halt only blocks new ones.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       state_next = (has_space && !halt) ? REQ : WAIT_SPACE;
      REQ: begin
        if (imem_ready) begin
          state_next = (has_space && !halt) ? REQ : WAIT_SPACE;
        end
      end
      WAIT_SPACE: state_next = (has_space && !halt) ? REQ : WAIT_SPACE;
      default:    state_next = IDLE;
    endcase
    if (ctrlFetch) begin
      state_next = REQ;
    end
  end

endmodule
